cache_port_arbiter: RTL and testbench
=====================================

# cache_port_arbiter

Sequencer and round-robin arbiter that lets two requesters (instruction fetch and data access) share the single CPU-side cache bus (A1/D1/C1). It accepts whole read/write transactions from each requester and replays them on the shared bus with the multi-cycle address, data and response phases the cache expects. It returns read data and a one-cycle ACK to the owning requester. It sits between the core's two memory ports and the cache.

## Interface
- ADDR1_BUS_SIZE, 15, tag+set width carried on A1
- CACHE_OFFSET_SIZE, 4, byte offset width, sent on A1 in the second address cycle
- DATA1_BUS_SIZE, 16, D1 width
- CTR1_BUS_SIZE, 3, C1 width
- TIMEOUT_CYCLES, 255, WAIT-state limit; used only with CACHE_ARB_TIMEOUT_EN
- clk  input  1  single clock; bus sampled on negedge, driven on posedge
- RESET  input  1  asynchronous, active-low
- REQ  input  2  per-client request; held until ACK
- CMD0, CMD1  input  3  C1 command code, READ8/16/32 or WRITE8/16/32
- ADDR0, ADDR1  input  ADDR1_BUS_SIZE+CACHE_OFFSET_SIZE  byte address {tag,set,offset}
- WDATA0, WDATA1  input  32  write data; low half first
- ACK  output  2  one-cycle completion pulse per client
- RDATA  output  32  read result, valid on the ACK cycle, held until the next ACK
- ERR  output  1  timeout pulse; present only with the macro
- A1  output  ADDR1_BUS_SIZE  cache address bus
- D1  inout  DATA1_BUS_SIZE  cache data bus, Z when not driven
- C1  inout  CTR1_BUS_SIZE  cache command bus, Z when not driven

## Operation
- Arbitration happens only in IDLE. A single REQ wins. If both are high, the client that was not granted last wins. The last-grant register resets to 1, so client 0 wins the first tie.
- Operands are latched at grant. REQ and operand changes after grant are ignored until ACK. A REQ dropped before grant is a withdrawn request.
- States: IDLE → CMD → OFFS → WAIT → (RD2 for READ32) → ACKS → IDLE.
  - CMD: drive C1=cmd and A1=addr[top ADDR1_BUS_SIZE bits]. Writes also drive D1=wdata[15:0].
  - OFFS: release C1. Drive A1={0,offset}. Drive D1=wdata[31:16] for WRITE32; release D1 otherwise.
  - WAIT: C1 and D1 are Z. Sample C1 at each negedge.
    - On C1==C1_RESPONSE: READ8 captures D1[7:0] zero-extended; READ16 captures D1 into RDATA[15:0] with upper half 0; READ32 captures the low half and goes to RD2; writes capture nothing.
  - RD2: capture D1 into RDATA[31:16] at the next negedge.
  - ACKS: ACK[granted]=1 for exactly one cycle, then IDLE.
- Unsupported CMD codes (NOP, INVALIDATE): the request is acknowledged in ACKS with no bus activity, and RDATA is unchanged.

## Timing
- Grant at posedge k drives CMD at posedge k+1 and OFFS at posedge k+2. WAIT starts at posedge k+3.
- Response seen at negedge n (plus negedge n+1 for READ32): ACK is high during the following clock period.
- Minimum latency from REQ to ACK is 5 cycles, plus cache latency.
- The posedge after ACKS is a turnaround cycle with no bus drive. The earliest next CMD is 2 cycles after ACK. Back-to-back alternating clients therefore never overlap drivers.
- Reset values: ACK=0, RDATA=0, ERR=0, A1=0, C1/D1=Z, state=IDLE, last-grant=1.
- Reset mid-transaction aborts immediately, with no ACK. The cache shares RESET and is reset too.

## Configuration
- CACHE_ARB_TIMEOUT_EN defined:
  - An 8-bit counter runs in WAIT.
  - When it reaches TIMEOUT_CYCLES, the arbiter pulses ERR and ACK[granted] together for one cycle with RDATA=0, then goes IDLE.
- Not defined: WAIT is unbounded, and the ERR port and counter are absent.

## Structure
- Package cache_bus_pkg holds:
  - C1 command codes: NOP=0, READ8=1, READ16=2, READ32=3, INVALIDATE=4, WRITE8=5, WRITE16=6, WRITE32=7, RESPONSE=7
  - bus width constants
  - state enum typedef
- Sub-module rr_arb2: 2-input round-robin grant with a last-grant register, combinational grant output and an update-on-accept input.

## Test plan
- Client 0 READ16 of 0x01234, cache responds 0xBEEF after 3 WAIT cycles → A1 shows 0x0123 then 0x4, ACK=01, RDATA=0x0000BEEF.
- Client 1 WRITE32 0xCAFEF00D → D1 shows 0xF00D in CMD and 0xCAFE in OFFS, then Z; ACK=10 after RESPONSE.
- Both REQ high continuously → grants alternate 0,1,0,1, and C1 is Z during every turnaround cycle.
- READ32 with response halves 0x1111 then 0x2222 → RDATA=0x22221111; READ8 with D1=0xAB12 → RDATA=0x00000012.
- RESET low during WAIT → ACK stays 0, C1/D1 are Z at once, and the next grant goes to client 0.
- With CACHE_ARB_TIMEOUT_EN and no response → ERR and ACK pulse after 255 WAIT cycles, RDATA=0.

Source files
------------

// File: rtl/cache_bus_pkg.sv
// cache_bus_pkg: shared constants and types for the CPU-side cache bus
// (A1/D1/C1) and the cache_port_arbiter that sequences transactions on it.
//   - bus width constants
//   - C1 command codes (RESPONSE reuses code 7, driven only by the cache)
//   - arbiter FSM state enum
//   - small command-decoding helpers
package cache_bus_pkg;

    localparam int ADDR1_BUS_SIZE    = 15;
    localparam int CACHE_OFFSET_SIZE = 4;
    localparam int DATA1_BUS_SIZE    = 16;
    localparam int CTR1_BUS_SIZE     = 3;
    localparam int TIMEOUT_CYCLES    = 255;
    localparam int BYTE_ADDR_SIZE    = ADDR1_BUS_SIZE + CACHE_OFFSET_SIZE;

    localparam logic [CTR1_BUS_SIZE-1:0] C1_NOP        = 3'd0;
    localparam logic [CTR1_BUS_SIZE-1:0] C1_READ8      = 3'd1;
    localparam logic [CTR1_BUS_SIZE-1:0] C1_READ16     = 3'd2;
    localparam logic [CTR1_BUS_SIZE-1:0] C1_READ32     = 3'd3;
    localparam logic [CTR1_BUS_SIZE-1:0] C1_INVALIDATE = 3'd4;
    localparam logic [CTR1_BUS_SIZE-1:0] C1_WRITE8     = 3'd5;
    localparam logic [CTR1_BUS_SIZE-1:0] C1_WRITE16    = 3'd6;
    localparam logic [CTR1_BUS_SIZE-1:0] C1_WRITE32    = 3'd7;
    localparam logic [CTR1_BUS_SIZE-1:0] C1_RESPONSE   = 3'd7;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_CMD  = 3'd1,
        ST_OFFS = 3'd2,
        ST_WAIT = 3'd3,
        ST_RD2  = 3'd4,
        ST_ACKS = 3'd5
    } arb_state_e;

    function automatic logic is_write(input logic [CTR1_BUS_SIZE-1:0] cmd);
        return (cmd == C1_WRITE8) || (cmd == C1_WRITE16) || (cmd == C1_WRITE32);
    endfunction

    // NOP and INVALIDATE are acknowledged without touching the bus.
    function automatic logic is_supported(input logic [CTR1_BUS_SIZE-1:0] cmd);
        return (cmd != C1_NOP) && (cmd != C1_INVALIDATE);
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-input round-robin arbiter.
//   clk, rst_n   : clock, asynchronous active-low reset
//   req_i[1:0]   : request per client
//   accept_i     : the current grant is taken; updates the last-grant register
//   gnt_o[1:0]   : one-hot combinational grant (zero when no request)
// On a tie the client that was not granted last wins. last_q resets to 1 so
// client 0 wins the first tie.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req_i,
    input  logic       accept_i,
    output logic [1:0] gnt_o
);

    logic last_q;

    always_comb begin
        gnt_o = req_i;
        if (req_i == 2'b11) begin
            gnt_o = last_q ? 2'b01 : 2'b10;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= 1'b1;
        end else if (accept_i && (gnt_o != 2'b00)) begin
            last_q <= gnt_o[1];
        end
    end

endmodule

// File: rtl/cache_port_arbiter.sv
// cache_port_arbiter: lets instruction fetch (client 0) and data access
// (client 1) share the CPU-side cache bus. Whole transactions are latched at
// grant and replayed as CMD / OFFS / WAIT (/ RD2) phases, then ACKed.
// Ports:
//   clk, RESET           : clock, asynchronous active-low reset
//   REQ[1:0]             : per-client request, held until ACK
//   CMD0/CMD1            : C1 command code per client
//   ADDR0/ADDR1          : byte address {tag,set,offset}
//   WDATA0/WDATA1        : write data, low half goes out first
//   ACK[1:0]             : one-cycle completion pulse to the owner
//   RDATA                : read result, updated only on entry to the ACK cycle
//   ERR                  : timeout pulse (only with CACHE_ARB_TIMEOUT_EN)
//   A1, D1, C1           : cache bus; D1/C1 are Z when not driven
//   dbg_state_o          : current FSM state
//   dbg_oe_o             : {C1 output enable, D1 output enable}
// Option macro CACHE_ARB_TIMEOUT_EN bounds the WAIT phase at TIMEOUT_CYCLES.
// Bus inputs are sampled on the falling edge; the FSM and bus drive change on
// the rising edge.
module cache_port_arbiter
    import cache_bus_pkg::*;
(
    input  logic                         clk,
    input  logic                         RESET,
    input  logic [1:0]                   REQ,
    input  logic [CTR1_BUS_SIZE-1:0]     CMD0,
    input  logic [CTR1_BUS_SIZE-1:0]     CMD1,
    input  logic [BYTE_ADDR_SIZE-1:0]    ADDR0,
    input  logic [BYTE_ADDR_SIZE-1:0]    ADDR1,
    input  logic [31:0]                  WDATA0,
    input  logic [31:0]                  WDATA1,
    output logic [1:0]                   ACK,
    output logic [31:0]                  RDATA,
`ifdef CACHE_ARB_TIMEOUT_EN
    output logic                         ERR,
`endif
    output logic [ADDR1_BUS_SIZE-1:0]    A1,
    inout  wire  [DATA1_BUS_SIZE-1:0]    D1,
    inout  wire  [CTR1_BUS_SIZE-1:0]     C1,
    output logic [2:0]                   dbg_state_o,
    output logic [1:0]                   dbg_oe_o
);

    arb_state_e                    state_q, state_d;
    logic [1:0]                    gnt;
    logic                          owner_q;
    logic [CTR1_BUS_SIZE-1:0]      cmd_q;
    logic [BYTE_ADDR_SIZE-1:0]     addr_q;
    logic [31:0]                   wdata_q;
    logic [31:0]                   rdata_q, rdata_d;
    logic [DATA1_BUS_SIZE-1:0]     rlow_q, rlow_d;
    logic [CTR1_BUS_SIZE-1:0]      c1_smp_q;
    logic [DATA1_BUS_SIZE-1:0]     d1_smp_q;
    logic                          c1_oe, d1_oe;
    logic [DATA1_BUS_SIZE-1:0]     d1_out;
    logic                          grant_now;

    rr_arb2 u_rr (
        .clk      (clk),
        .rst_n    (RESET),
        .req_i    (REQ),
        .accept_i (state_q == ST_IDLE),
        .gnt_o    (gnt)
    );

    assign grant_now = (state_q == ST_IDLE) && (gnt != 2'b00);

`ifdef CACHE_ARB_TIMEOUT_EN
    logic [7:0] cnt_q;
    logic       err_q, err_d;
    logic       timeout;

    assign timeout = (cnt_q == 8'(TIMEOUT_CYCLES - 1));
    assign ERR     = err_q;

    always_ff @(posedge clk or negedge RESET) begin
        if (!RESET) begin
            cnt_q <= 8'd0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= (state_q == ST_WAIT) ? cnt_q + 8'd1 : 8'd0;
            err_q <= err_d;
        end
    end
`endif

    // Falling-edge samples of the cache-driven bus, used by WAIT and RD2.
    always_ff @(negedge clk or negedge RESET) begin
        if (!RESET) begin
            c1_smp_q <= '0;
            d1_smp_q <= '0;
        end else begin
            c1_smp_q <= C1;
            d1_smp_q <= D1;
        end
    end

    always_ff @(posedge clk or negedge RESET) begin
        if (!RESET) begin
            state_q <= ST_IDLE;
            owner_q <= 1'b0;
            cmd_q   <= C1_NOP;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            rlow_q  <= '0;
        end else begin
            state_q <= state_d;
            rdata_q <= rdata_d;
            rlow_q  <= rlow_d;
            if (grant_now) begin
                owner_q <= gnt[1];
                cmd_q   <= gnt[1] ? CMD1   : CMD0;
                addr_q  <= gnt[1] ? ADDR1  : ADDR0;
                wdata_q <= gnt[1] ? WDATA1 : WDATA0;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        rdata_d = rdata_q;
        rlow_d  = rlow_q;
`ifdef CACHE_ARB_TIMEOUT_EN
        err_d   = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (grant_now) begin
                    state_d = is_supported(gnt[1] ? CMD1 : CMD0) ? ST_CMD : ST_ACKS;
                end
            end
            ST_CMD:  state_d = ST_OFFS;
            ST_OFFS: state_d = ST_WAIT;
            ST_WAIT: begin
                if (c1_smp_q == C1_RESPONSE) begin
                    state_d = ST_ACKS;
                    case (cmd_q)
                        C1_READ8:  rdata_d = {24'd0, d1_smp_q[7:0]};
                        C1_READ16: rdata_d = {16'd0, d1_smp_q};
                        C1_READ32: begin
                            rlow_d  = d1_smp_q;
                            state_d = ST_RD2;
                        end
                        default: ;
                    endcase
                end
`ifdef CACHE_ARB_TIMEOUT_EN
                else if (timeout) begin
                    state_d = ST_ACKS;
                    rdata_d = '0;
                    err_d   = 1'b1;
                end
`endif
            end
            ST_RD2: begin
                rdata_d = {d1_smp_q, rlow_q};
                state_d = ST_ACKS;
            end
            ST_ACKS: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Bus drive decodes directly from the registered state, so reset
    // releases C1/D1 immediately.
    always_comb begin
        c1_oe  = (state_q == ST_CMD);
        d1_oe  = ((state_q == ST_CMD) && is_write(cmd_q)) ||
                 ((state_q == ST_OFFS) && (cmd_q == C1_WRITE32));
        d1_out = (state_q == ST_CMD) ? wdata_q[15:0] : wdata_q[31:16];
        A1     = '0;
        if (state_q == ST_CMD) begin
            A1 = addr_q[BYTE_ADDR_SIZE-1:CACHE_OFFSET_SIZE];
        end else if (state_q == ST_OFFS) begin
            A1 = {{(ADDR1_BUS_SIZE-CACHE_OFFSET_SIZE){1'b0}}, addr_q[CACHE_OFFSET_SIZE-1:0]};
        end
    end

    assign C1          = c1_oe ? cmd_q  : 'z;
    assign D1          = d1_oe ? d1_out : 'z;
    assign ACK         = (state_q == ST_ACKS) ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
    assign RDATA       = rdata_q;
    assign dbg_state_o = state_q;
    assign dbg_oe_o    = {c1_oe, d1_oe};

endmodule

// File: tb/tb_cache_port_arbiter.sv
// Directed bench for cache_port_arbiter. The bench plays the cache on C1/D1
// and checks bus phases, grants, ACK pulses and RDATA against hand-computed
// values. With CACHE_ARB_TIMEOUT_EN defined it also covers the WAIT timeout.
module tb_cache_port_arbiter;
    import cache_bus_pkg::*;

    logic        clk = 1'b0;
    logic        RESET;
    logic [1:0]  REQ;
    logic [2:0]  CMD0, CMD1;
    logic [18:0] ADDR0, ADDR1;
    logic [31:0] WDATA0, WDATA1;
    wire  [1:0]  ACK;
    wire  [31:0] RDATA;
    wire  [14:0] A1;
    wire  [15:0] D1;
    wire  [2:0]  C1;
    wire  [2:0]  dbg_state;
    wire  [1:0]  dbg_oe;
`ifdef CACHE_ARB_TIMEOUT_EN
    wire         ERR;
`endif

    logic        cache_en;
    logic [2:0]  cache_c1;
    logic [15:0] cache_d1;

    assign C1 = cache_en ? cache_c1 : 'z;
    assign D1 = cache_en ? cache_d1 : 'z;

    int checks = 0;
    int errors = 0;

    cache_port_arbiter dut (
        .clk         (clk),
        .RESET       (RESET),
        .REQ         (REQ),
        .CMD0        (CMD0),
        .CMD1        (CMD1),
        .ADDR0       (ADDR0),
        .ADDR1       (ADDR1),
        .WDATA0      (WDATA0),
        .WDATA1      (WDATA1),
        .ACK         (ACK),
        .RDATA       (RDATA),
`ifdef CACHE_ARB_TIMEOUT_EN
        .ERR         (ERR),
`endif
        .A1          (A1),
        .D1          (D1),
        .C1          (C1),
        .dbg_state_o (dbg_state),
        .dbg_oe_o    (dbg_oe)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    // driver / check tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wait_state(input logic [2:0] st, input int budget, input string tag);
        int n = 0;
        while (dbg_state !== st && n < budget) begin
            tick();
            n++;
        end
        check(tag, {29'd0, dbg_state}, {29'd0, st});
    endtask

    // Cache answers RESPONSE with one data half, sampled on the next negedge.
    task automatic respond(input logic [15:0] d);
        cache_en = 1'b1;
        cache_c1 = C1_RESPONSE;
        cache_d1 = d;
        tick();
        cache_en = 1'b0;
    endtask

    logic [15:0] t3_d   [4] = '{16'hAB12, 16'h34CD, 16'h5678, 16'h9A0F};
    logic [31:0] t3_r   [4] = '{32'h12, 32'hCD, 32'h78, 32'h0F};
    logic [1:0]  t3_ack [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
    logic [14:0] t3_a1  [4] = '{15'h001, 15'h002, 15'h001, 15'h002};

    initial begin
        RESET = 1'b0; REQ = 2'b00;
        CMD0 = C1_NOP; CMD1 = C1_NOP;
        ADDR0 = '0; ADDR1 = '0; WDATA0 = '0; WDATA1 = '0;
        cache_en = 1'b0; cache_c1 = '0; cache_d1 = '0;
        repeat (2) tick();

        // reset state
        check("rst_ack",   {30'd0, ACK},       32'd0);
        check("rst_rdata", RDATA,              32'd0);
        check("rst_a1",    {17'd0, A1},        32'd0);
        check("rst_oe",    {30'd0, dbg_oe},    32'd0);
        check("rst_state", {29'd0, dbg_state}, 32'(ST_IDLE));
        RESET = 1'b1;
        tick();

        // client 0 READ16 of 0x01234, response 0xBEEF after 3 WAIT cycles
        CMD0 = C1_READ16; ADDR0 = 19'h01234; REQ = 2'b01;
        tick();
        check("r16_state_cmd", {29'd0, dbg_state}, 32'(ST_CMD));
        check("r16_c1",        {29'd0, C1},        32'(C1_READ16));
        check("r16_a1_cmd",    {17'd0, A1},        32'h0123);
        check("r16_oe_cmd",    {30'd0, dbg_oe},    32'b10);
        tick();
        check("r16_state_offs", {29'd0, dbg_state}, 32'(ST_OFFS));
        check("r16_a1_offs",    {17'd0, A1},        32'h0004);
        check("r16_oe_offs",    {30'd0, dbg_oe},    32'b00);
        tick();
        check("r16_state_wait", {29'd0, dbg_state}, 32'(ST_WAIT));
        check("r16_oe_wait",    {30'd0, dbg_oe},    32'b00);
        tick();
        tick();
        check("r16_no_early_ack", {30'd0, ACK}, 32'd0);
        respond(16'hBEEF);
        check("r16_ack",   {30'd0, ACK}, 32'b01);
        check("r16_rdata", RDATA,        32'h0000BEEF);
        REQ = 2'b00;
        tick();
        check("r16_ack_drop", {30'd0, ACK},       32'd0);
        check("r16_idle",     {29'd0, dbg_state}, 32'(ST_IDLE));
        check("r16_hold",     RDATA,              32'h0000BEEF);

        // client 1 WRITE32 0xCAFEF00D
        CMD1 = C1_WRITE32; ADDR1 = 19'h7FFF5; WDATA1 = 32'hCAFEF00D; REQ = 2'b10;
        tick();
        check("w32_c1",     {29'd0, C1},     32'(C1_WRITE32));
        check("w32_d1_cmd", {16'd0, D1},     32'hF00D);
        check("w32_a1_cmd", {17'd0, A1},     32'h7FFF);
        check("w32_oe_cmd", {30'd0, dbg_oe}, 32'b11);
        tick();
        check("w32_d1_offs", {16'd0, D1},     32'hCAFE);
        check("w32_a1_offs", {17'd0, A1},     32'h0005);
        check("w32_oe_offs", {30'd0, dbg_oe}, 32'b01);
        tick();
        check("w32_oe_wait", {30'd0, dbg_oe}, 32'b00);
        respond(16'h0000);
        check("w32_ack",   {30'd0, ACK}, 32'b10);
        check("w32_rdata", RDATA,        32'h0000BEEF);
        REQ = 2'b00;
        tick();

        // both clients request continuously with READ8: grants alternate
        CMD0 = C1_READ8; ADDR0 = 19'h00010;
        CMD1 = C1_READ8; ADDR1 = 19'h00020;
        REQ = 2'b11;
        for (int i = 0; i < 4; i++) begin
            wait_state(ST_CMD, 4, "alt_cmd");
            check("alt_a1", {17'd0, A1}, {17'd0, t3_a1[i]});
            tick();
            tick();
            respond(t3_d[i]);
            check("alt_ack",   {30'd0, ACK}, {30'd0, t3_ack[i]});
            check("alt_rdata", RDATA,        t3_r[i]);
            tick();
            check("alt_turn_state", {29'd0, dbg_state}, 32'(ST_IDLE));
            check("alt_turn_oe",    {30'd0, dbg_oe},    32'b00);
        end
        REQ = 2'b00;
        tick();

        // READ32: halves 0x1111 then 0x2222
        CMD0 = C1_READ32; ADDR0 = 19'h0ABC3; REQ = 2'b01;
        tick();
        check("r32_c1", {29'd0, C1}, 32'(C1_READ32));
        tick();
        check("r32_oe_offs", {30'd0, dbg_oe}, 32'b00);
        tick();
        cache_en = 1'b1; cache_c1 = C1_RESPONSE; cache_d1 = 16'h1111;
        tick();
        check("r32_rd2", {29'd0, dbg_state}, 32'(ST_RD2));
        cache_d1 = 16'h2222;
        tick();
        cache_en = 1'b0;
        check("r32_ack",   {30'd0, ACK}, 32'b01);
        check("r32_rdata", RDATA,        32'h22221111);
        REQ = 2'b00;
        tick();

        // unsupported command: ACK without bus activity, RDATA unchanged
        CMD1 = C1_NOP; REQ = 2'b10;
        tick();
        check("nop_state", {29'd0, dbg_state}, 32'(ST_ACKS));
        check("nop_ack",   {30'd0, ACK},       32'b10);
        check("nop_oe",    {30'd0, dbg_oe},    32'b00);
        check("nop_rdata", RDATA,              32'h22221111);
        REQ = 2'b00;
        tick();
        check("nop_ack_drop", {30'd0, ACK}, 32'd0);

        // reset during WAIT (client 0 granted last), then a tie goes to client 0
        CMD0 = C1_READ16; ADDR0 = 19'h12345; REQ = 2'b01;
        tick();
        tick();
        tick();
        check("rstw_wait", {29'd0, dbg_state}, 32'(ST_WAIT));
        RESET = 1'b0;
        #1;
        check("rstw_state", {29'd0, dbg_state}, 32'(ST_IDLE));
        check("rstw_oe",    {30'd0, dbg_oe},    32'b00);
        check("rstw_ack",   {30'd0, ACK},       32'd0);
        check("rstw_rdata", RDATA,              32'd0);
        tick();
        CMD1 = C1_READ8; ADDR1 = 19'h00770; REQ = 2'b11; RESET = 1'b1;
        tick();
        check("rstw_tie_c1", {29'd0, C1}, 32'(C1_READ16));
        check("rstw_tie_a1", {17'd0, A1}, 32'h1234);
        REQ = 2'b01;
        tick();
        tick();
        respond(16'h0042);
        check("rstw_ack2",   {30'd0, ACK}, 32'b01);
        check("rstw_rdata2", RDATA,        32'h00000042);
        REQ = 2'b00;
        tick();

`ifdef CACHE_ARB_TIMEOUT_EN
        // no response: ERR and ACK after 255 WAIT cycles, RDATA cleared
        CMD1 = C1_WRITE8; ADDR1 = 19'h00100; WDATA1 = 32'h55; REQ = 2'b10;
        tick();
        tick();
        tick();
        check("to_wait", {29'd0, dbg_state}, 32'(ST_WAIT));
        repeat (254) tick();
        check("to_still_wait", {29'd0, dbg_state}, 32'(ST_WAIT));
        check("to_err_low",    {31'd0, ERR},       32'd0);
        tick();
        check("to_err",   {31'd0, ERR},  32'd1);
        check("to_ack",   {30'd0, ACK},  32'b10);
        check("to_rdata", RDATA,         32'd0);
        REQ = 2'b00;
        tick();
        check("to_err_drop", {31'd0, ERR},       32'd0);
        check("to_idle",     {29'd0, dbg_state}, 32'(ST_IDLE));
`endif

        // report
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
